imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake and produces a sign- or zero-extended XLEN-wide immediate plus a format code. A two-entry skid buffer registers the outputs, so back-pressure from execute never loses or reorders instructions. It covers all base formats (I, S, B, U, J, shift-immediate) and supports both RV32 and RV64.

---
 rtl/imm_gen_pkg.sv | 49 ++++
 rtl/imm_decode.sv | 92 +++++++++
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: formats, opcodes, buffer states and the entry bundle
// shared by imm_decode and imm_gen_pipe (IMM_GEN_ILLEGAL_EN adds illegal).
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HALF  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int IMM_W     = 64;
  localparam int TAG_MAX_W = 64;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [IMM_W-1:0]     imm;
    imm_fmt_e             fmt;
    logic [TAG_MAX_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_EN
    logic                 illegal;
`endif
  } imm_entry_t;

  function automatic logic [IMM_W-1:0] sext32(
    input logic [31:0] v
  );
    return {{(IMM_W-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational instruction -> entry decode (inst, tag in;
// ent out). Builds a 64-bit immediate; the top keeps the low XLEN bits.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          inst,
  input  logic [TAG_MAX_W-1:0] tag,
  output imm_entry_t           ent
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic             rv64;
  logic             op_imm32;
  logic             is_opimm;
  logic             sh_f3;
  logic             is_sh;
  logic             is_i;
  logic             is_u;
  logic [IMM_W-1:0] shamt;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign rv64     = (XLEN == 64);
  // OP-IMM-32 only exists on RV64
  assign op_imm32 = rv64 && (opc == OPC_OP_IMM32);
  assign is_opimm = (opc == OPC_OP_IMM) || op_imm32;
  assign sh_f3    = (f3 == 3'b001) || (f3 == 3'b101);
  assign is_sh    = is_opimm && sh_f3;
  assign is_i     = (is_opimm && !sh_f3)
                  || (opc == OPC_LOAD)
                  || (opc == OPC_JALR);
  assign is_u     = (opc == OPC_LUI)
                  || (opc == OPC_AUIPC);

  // 6-bit shamt only for full-width RV64 shifts
  assign shamt = (rv64 && opc == OPC_OP_IMM)
               ? IMM_W'(inst[25:20])
               : IMM_W'(inst[24:20]);

  always_comb begin
    ent     = '0;
    ent.tag = tag;
    unique case (1'b1)
      is_sh: begin
        ent.fmt = FMT_SH;
        ent.imm = shamt;
      end
      is_i: begin
        ent.fmt = FMT_I;
        ent.imm = sext32({{20{inst[31]}},
                          inst[31:20]});
      end
      (opc == OPC_STORE): begin
        ent.fmt = FMT_S;
        ent.imm = sext32({{20{inst[31]}},
                          inst[31:25],
                          inst[11:7]});
      end
      (opc == OPC_BRANCH): begin
        ent.fmt = FMT_B;
        ent.imm = sext32({{19{inst[31]}},
                          inst[31], inst[7],
                          inst[30:25],
                          inst[11:8], 1'b0});
      end
      is_u: begin
        ent.fmt = FMT_U;
        ent.imm = sext32({inst[31:12],
                          12'b0});
      end
      (opc == OPC_JAL): begin
        ent.fmt = FMT_J;
        ent.imm = sext32({{11{inst[31]}},
                          inst[31],
                          inst[19:12],
                          inst[20],
                          inst[30:21],
                          1'b0});
      end
      default: begin
        ent.fmt = FMT_NONE;
      end
    endcase
`ifdef IMM_GEN_ILLEGAL_EN
    ent.illegal = (ent.fmt == FMT_NONE);
`endif
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator behind a 2-entry skid
// buffer. in_*/out_* valid-ready handshakes, flush; IMM_GEN_ILLEGAL_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  buf_state_e state_q;
  buf_state_e state_d;
  imm_entry_t main_q;
  imm_entry_t skid_q;
  imm_entry_t dec;
  logic       accept;
  logic       drain;
  logic       load_main;
  logic       load_skid;
  logic       pop_skid;
  logic       unused_ok;

  imm_decode #(
    .XLEN (XLEN)
  ) u_dec (
    .inst (in_inst),
    .tag  (TAG_MAX_W'(in_tag)),
    .ent  (dec)
  );

  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = BUF_HALF;
        end
      end
      BUF_HALF: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = BUF_FULL;
        end else if (drain) begin
          state_d   = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (drain) begin
          pop_skid = 1'b1;
          state_d  = BUF_HALF;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    // flush wins over any handshake this cycle
    if (flush) begin
      state_d   = BUF_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_q <= dec;
      end else if (pop_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign out_imm = main_q.imm[XLEN-1:0];
  assign out_fmt = main_q.fmt;
  assign out_tag = main_q.tag[TAG_W-1:0];
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = main_q.illegal;
`endif

  // upper imm/tag bits beyond XLEN/TAG_W are constant-extended
  assign unused_ok = ^{main_q.imm, main_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: RV32 and RV64 instances on shared stimulus, checked
// against a queue model plus field-arithmetic immediate reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_tag;

  logic        rdy32, ov32, rdy64, ov64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        ill32, ill64;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } item_t;
  item_t mq[$];

  logic [6:0] ops [0:10] = '{
    7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63,
    7'h37, 7'h17, 7'h6F, 7'h0B, 7'h33};

  logic [31:0] s_inst [0:3] = '{
    32'hFFF00093, 32'hFE112E23,
    32'hFE000CE3, 32'h123450B7};
  logic [31:0] s_e32 [0:3] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC,
    32'hFFFFFFF8, 32'h12345000};
  logic [63:0] s_e64 [0:3] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
    64'hFFFFFFFFFFFFFFF8, 64'h0000000012345000};
  logic [2:0] s_fmt [0:3] = '{3'd1, 3'd2, 3'd3, 3'd4};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(ill32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(ill64)
`endif
  );

  function automatic int ref_fmt(logic [31:0] i, int xlen);
    bit sh;
    sh = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
    case (i[6:0])
      7'h03, 7'h67: return 1;
      7'h13:        return sh ? 6 : 1;
      7'h1B:        return (xlen != 64) ? 0 : (sh ? 6 : 1);
      7'h23:        return 2;
      7'h63:        return 3;
      7'h37, 7'h17: return 4;
      7'h6F:        return 5;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] i, int xlen);
    longint v;
    longint s;
    s = longint'(i[31]);
    case (ref_fmt(i, xlen))
      1: v = longint'(i[30:20]) - 2048 * s;
      2: v = longint'(i[11:7]) + 32 * longint'(i[30:25]) - 2048 * s;
      3: v = 2 * longint'(i[11:8]) + 32 * longint'(i[30:25])
           + 2048 * longint'(i[7]) - 4096 * s;
      4: v = 4096 * longint'(i[30:12]) - (64'sd1 <<< 31) * s;
      5: v = 2 * longint'(i[30:21]) + 2048 * longint'(i[20])
           + 4096 * longint'(i[19:12]) - 1048576 * s;
      6: v = (xlen == 64 && i[6:0] == 7'h13)
           ? longint'(i[25:20]) : longint'(i[24:20]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h00000000FFFFFFFF;
    return v;
  endfunction

  // one clock edge; the queue model applies flush/drain/accept
  task automatic tick();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{in_inst, in_tag});
    end
    #1;
  endtask

  task automatic idle(int n);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_inst = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", ov32, ov64); end
    checks++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b want 1", rdy32, rdy64); end
    checks++; if (imm32 !== '0 || imm64 !== '0) begin errors++; $display("FAIL reset_imm got %h/%h want 0", imm32, imm64); end
    checks++; if (fmt32 !== 3'd0 || fmt64 !== 3'd0 || tag32 !== '0 || tag64 !== '0) begin errors++; $display("FAIL reset_fmt_tag got %h %h %h %h want 0", fmt32, fmt64, tag32, tag64); end
`ifdef IMM_GEN_ILLEGAL_EN
    checks++; if (ill32 !== 1'b0 || ill64 !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b/%b want 0", ill32, ill64); end
`endif
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_inst = s_inst[k]; in_tag = 32'(k + 1);
      tick();
      checks++; if (ov32 !== 1'b1 || imm32 !== s_e32[k] || fmt32 !== s_fmt[k] || tag32 !== 32'(k + 1)) begin errors++; $display("FAIL stream32_%0d got v%b %h f%0d t%0h want %h f%0d t%0h", k, ov32, imm32, fmt32, tag32, s_e32[k], s_fmt[k], k + 1); end
      checks++; if (ov64 !== 1'b1 || imm64 !== s_e64[k] || fmt64 !== s_fmt[k]) begin errors++; $display("FAIL stream64_%0d got v%b %h f%0d want %h f%0d", k, ov64, imm64, fmt64, s_e64[k], s_fmt[k]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL stream_empty got %b/%b want 0", ov32, ov64); end
  endtask

  task automatic test_shift();
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h4030D093; in_tag = 32'hA1;
    tick();
    checks++; if (imm32 !== 32'd3 || fmt32 !== 3'd6) begin errors++; $display("FAIL srai32 got %h f%0d want 3 f6", imm32, fmt32); end
    checks++; if (imm64 !== 64'd3 || fmt64 !== 3'd6) begin errors++; $display("FAIL srai64 got %h f%0d want 3 f6", imm64, fmt64); end
    in_inst = 32'h4230D093;
    tick();
    checks++; if (imm64 !== 64'd35 || fmt64 !== 3'd6) begin errors++; $display("FAIL srai64_b25 got %h f%0d want 35 f6", imm64, fmt64); end
    checks++; if (imm32 !== 32'd3) begin errors++; $display("FAIL srai32_b25 got %h want 3", imm32); end
    in_inst = 32'h0250101B;
    tick();
    checks++; if (imm64 !== 64'd5 || fmt64 !== 3'd6) begin errors++; $display("FAIL slliw64 got %h f%0d want 5 f6", imm64, fmt64); end
    checks++; if (imm32 !== 32'd0 || fmt32 !== 3'd0) begin errors++; $display("FAIL slliw32 got %h f%0d want 0 f0", imm32, fmt32); end
`ifdef IMM_GEN_ILLEGAL_EN
    checks++; if (ill32 !== 1'b1 || ill64 !== 1'b0) begin errors++; $display("FAIL slliw_illegal got %b/%b want 1/0", ill32, ill64); end
`endif
    idle(1);
  endtask

  task automatic test_unknown();
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = 32'h0000000B; in_tag = 32'hB2;
    tick();
    checks++; if (ov32 !== 1'b1 || imm32 !== '0 || fmt32 !== 3'd0 || imm64 !== '0 || fmt64 !== 3'd0) begin errors++; $display("FAIL unknown got %h f%0d %h f%0d want 0 f0", imm32, fmt32, imm64, fmt64); end
`ifdef IMM_GEN_ILLEGAL_EN
    checks++; if (ill32 !== 1'b1 || ill64 !== 1'b1) begin errors++; $display("FAIL unknown_illegal got %b/%b want 1", ill32, ill64); end
`endif
    idle(1);
  endtask

  task automatic test_back_pressure();
    logic [31:0] h_imm, h_tag;
    logic [2:0]  h_fmt;
    int nacc, first, last;
    logic [31:0] seen[$];
    nacc = 0; first = -1; last = -1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = (nacc < 4);
      in_inst  = s_inst[nacc % 4];
      in_tag   = 32'h100 + 32'(nacc);
      if (in_valid && mq.size() < 2) nacc++;
      tick();
      if (c == 0) begin
        h_imm = imm32; h_tag = tag32; h_fmt = fmt32;
        checks++; if (h_tag !== 32'h100 || h_imm !== s_e32[0]) begin errors++; $display("FAIL bp_head got t%h %h want t100 %h", h_tag, h_imm, s_e32[0]); end
      end else begin
        checks++; if (imm32 !== h_imm || fmt32 !== h_fmt || tag32 !== h_tag || ov32 !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d got %h f%0d t%h want %h f%0d t%h", c, imm32, fmt32, tag32, h_imm, h_fmt, h_tag); end
      end
      if (c == 1) begin
        checks++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b/%b want 0", rdy32, rdy64); end
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (nacc < 4);
      in_inst  = s_inst[nacc % 4];
      in_tag   = 32'h100 + 32'(nacc);
      if (ov32) begin
        seen.push_back(tag32);
        if (first < 0) first = c;
        last = c;
      end
      if (in_valid && mq.size() < 2) nacc++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (seen.size() != 4 || last - first != 3) begin errors++; $display("FAIL bp_drain_count got %0d over %0d cycles want 4 over 4", seen.size(), last - first + 1); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 32'h100 + 32'(k)) begin errors++; $display("FAIL bp_order_%0d got %h want %h", k, seen[k], 32'h100 + 32'(k)); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = s_inst[0]; in_tag = 32'hC1; tick();
    in_inst = s_inst[1]; in_tag = 32'hC2; tick();
    checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL flush_full got ready %b want 0", rdy32); end
    in_inst = s_inst[3]; in_tag = 32'hF1; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL flush_valid got %b/%b want 0", ov32, ov64); end
    checks++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("FAIL flush_ready got %b/%b want 1", rdy32, rdy64); end
    in_tag = 32'hF2; tick();
    in_tag = 32'hF3; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL flush_gone_%0d got %b/%b t%h want 0", c, ov32, ov64, tag32); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = s_inst[0]; in_tag = 32'h55;
    tick();
    in_valid = 1'b0;
    checks++; if (ov32 !== 1'b1 || tag32 !== 32'h55) begin errors++; $display("FAIL ar_half got %b t%h want 1 t55", ov32, tag32); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("FAIL ar_state got v%b%b r%b%b want v00 r11", ov32, ov64, rdy32, rdy64); end
    checks++; if (imm32 !== '0 || imm64 !== '0 || fmt32 !== '0 || tag32 !== '0 || tag64 !== '0) begin errors++; $display("FAIL ar_out got %h %h %h %h want 0", imm32, imm64, fmt32, tag32); end
    mq.delete();
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_inst = s_inst[3]; in_tag = 32'h77;
    tick();
    in_valid = 1'b0;
    checks++; if (ov32 !== 1'b1 || imm32 !== 32'h12345000 || tag32 !== 32'h77) begin errors++; $display("FAIL ar_first got v%b %h t%h want 1 12345000 t77", ov32, imm32, tag32); end
    idle(2);
  endtask

  task automatic test_random();
    logic [63:0] e32, e64;
    int f32, f64;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_inst   = $urandom;
      in_inst[6:0] = ops[$urandom_range(0, 10)];
      in_tag    = $urandom;
      tick();
      checks++; if (ov32 !== (mq.size() > 0) || ov64 !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid_%0d got %b/%b want %b", n, ov32, ov64, mq.size() > 0); end
      checks++; if (rdy32 !== (mq.size() < 2) || rdy64 !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready_%0d got %b/%b want %b", n, rdy32, rdy64, mq.size() < 2); end
      if (mq.size() > 0) begin
        e32 = ref_imm(mq[0].inst, 32); f32 = ref_fmt(mq[0].inst, 32);
        e64 = ref_imm(mq[0].inst, 64); f64 = ref_fmt(mq[0].inst, 64);
        checks++; if (imm32 !== e32[31:0] || fmt32 !== 3'(f32) || tag32 !== mq[0].tag) begin errors++; $display("FAIL rnd32_%0d inst %h got %h f%0d t%h want %h f%0d t%h", n, mq[0].inst, imm32, fmt32, tag32, e32[31:0], f32, mq[0].tag); end
        checks++; if (imm64 !== e64 || fmt64 !== 3'(f64) || tag64 !== mq[0].tag) begin errors++; $display("FAIL rnd64_%0d inst %h got %h f%0d t%h want %h f%0d t%h", n, mq[0].inst, imm64, fmt64, tag64, e64, f64, mq[0].tag); end
`ifdef IMM_GEN_ILLEGAL_EN
        checks++; if (ill32 !== (f32 == 0) || ill64 !== (f64 == 0)) begin errors++; $display("FAIL rnd_illegal_%0d got %b/%b want %b/%b", n, ill32, ill64, f32 == 0, f64 == 0); end
`endif
      end
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_shift();
    test_unknown();
    test_back_pressure();
    idle(2);
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
